byte_unstrip: RTL and testbench

//  Receive-side partner of the 4-lane byte striper. Accepts one 4-lane symbol group per

---
 rtl/byte_unstrip_if.sv | 33 +++
 rtl/byte_unstrip.sv | 142 ++++++++++++++
 tb/tb_byte_unstrip.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/byte_unstrip_if.sv
// Lane-group input and serial byte output
// bundle for the 4-lane byte unstriper.
interface byte_unstrip_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] lane0;
  logic [BITS-1:0] lane1;
  logic [BITS-1:0] lane2;
  logic [BITS-1:0] lane3;
  logic [3:0]      in_k;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] out_data;
  logic            out_k;
  logic            out_valid;
  logic            out_ready;
  logic            in_pkt;
  logic            frame_err;

  modport master (
    output lane0, lane1, lane2, lane3,
    output in_k, in_valid, out_ready,
    input  in_ready, out_data, out_k,
    input  out_valid, in_pkt, frame_err
  );

  modport slave (
    input  lane0, lane1, lane2, lane3,
    input  in_k, in_valid, out_ready,
    output in_ready, out_data, out_k,
    output out_valid, in_pkt, frame_err
  );
endinterface

// File: rtl/byte_unstrip.sv
// Re-serialises 4-lane symbol groups into one
// byte stream, lane0 first, with framing checks.
module byte_unstrip #(
  parameter int LANES = 4,
  parameter int BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  byte_unstrip_if.slave  bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  localparam logic [BITS-1:0] STP = BITS'(8'hFB);
  localparam logic [BITS-1:0] SDP = BITS'(8'h5C);
  localparam logic [BITS-1:0] END = BITS'(8'hFD);
  localparam logic [BITS-1:0] EDB = BITS'(8'hFE);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state;
  state_t nstate;

  logic [BITS-1:0]  dbuf [LANES];
  logic [LANES-1:0] kbuf;
  logic [IW-1:0]    idx;
  logic [BITS-1:0]  lanes [LANES];

  logic             pkt;
  logic             ferr;
  logic             accept;
  logic             advance;
  logic             last;

  logic [LANES-1:0] is_start;
  logic [LANES-1:0] is_end;
  logic             misplaced;
  logic             pkt_mid;
  logic             pkt_next;
  logic             err;

  assign lanes[0] = bus.lane0;
  assign lanes[1] = bus.lane1;
  assign lanes[2] = bus.lane2;
  assign lanes[3] = bus.lane3;

  assign last    = (idx == LAST);
  assign advance = (state == SEND) & bus.out_ready;
  assign accept  = bus.in_valid & bus.in_ready;

  assign bus.in_pkt    = pkt;
  assign bus.frame_err = ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) nstate = SEND;
      end
      SEND: begin
        if (bus.out_ready && last && !bus.in_valid)
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_k     = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
      end
      SEND: begin
        bus.in_ready  = last & bus.out_ready;
        bus.out_valid = 1'b1;
        bus.out_data  = dbuf[idx];
        bus.out_k     = kbuf[idx];
      end
      default: ;
    endcase
  end

  // Framing is classified on the group as it arrives, before buffering
  always_comb begin
    is_start = '0;
    is_end   = '0;
    for (int i = 0; i < LANES; i++) begin
      is_start[i] = bus.in_k[i] &
                    ((lanes[i] == STP) | (lanes[i] == SDP));
      is_end[i]   = bus.in_k[i] &
                    ((lanes[i] == END) | (lanes[i] == EDB));
    end
  end

  assign misplaced = (|is_start[LANES-1:1]) |
                     (|is_end[LANES-2:0]);
  assign pkt_mid   = pkt | is_start[0];
  assign pkt_next  = is_end[LANES-1] ? 1'b0 : pkt_mid;
  assign err       = misplaced |
                     (is_start[0] & pkt) |
                     (is_end[LANES-1] & ~pkt_mid);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      kbuf <= '0;
      pkt  <= 1'b0;
      ferr <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        dbuf[i] <= '0;
      end
    end else begin
      ferr <= accept & err;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          dbuf[i] <= lanes[i];
        end
        kbuf <= bus.in_k[LANES-1:0];
        idx  <= '0;
        pkt  <= pkt_next;
      end else if (advance) begin
        // wraps to 0 after the last lane
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_byte_unstrip.sv
// Directed bench for byte_unstrip: serialisation,
// back-pressure, reset and framing checks.
module tb_byte_unstrip;
  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;

  byte_unstrip_if #(.BITS(8)) bus ();

  byte_unstrip #(
    .LANES(4),
    .BITS (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] l0,
                       input logic [7:0] l1,
                       input logic [7:0] l2,
                       input logic [7:0] l3,
                       input logic [3:0] k);
    bus.lane0    = l0;
    bus.lane1    = l1;
    bus.lane2    = l2;
    bus.lane3    = l3;
    bus.in_k     = k;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_group(input string tag,
                           input logic [7:0] l0,
                           input logic [7:0] l1,
                           input logic [7:0] l2,
                           input logic [7:0] l3,
                           input logic [3:0] k,
                           input logic exp_err,
                           input logic exp_pkt);
    logic [7:0] b [4];
    b[0] = l0;
    b[1] = l1;
    b[2] = l2;
    b[3] = l3;
    drive(l0, l1, l2, l3, k);
    #1;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_err"}, 32'(bus.frame_err), 32'(exp_err));
    chk({tag, "_pkt"}, 32'(bus.in_pkt), 32'(exp_pkt));
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_dat"}, 32'(bus.out_data), 32'(b[i]));
      chk({tag, "_k"}, 32'(bus.out_k), 32'(k[i]));
      if (i == 1)
        chk({tag, "_err1"}, 32'(bus.frame_err), 32'd0);
      tick();
    end
    chk({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_pkt_end"}, 32'(bus.in_pkt), 32'(exp_pkt));
  endtask

  initial begin
    logic [7:0] s2 [8];
    logic       k2 [8];
    passed = 0;
    failed = 0;
    total  = 0;
    rst          = 1'b1;
    bus.lane0    = '0;
    bus.lane1    = '0;
    bus.lane2    = '0;
    bus.lane3    = '0;
    bus.in_k     = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_dat", 32'(bus.out_data), 32'd0);
    chk("rst_k", 32'(bus.out_k), 32'd0);
    chk("rst_pkt", 32'(bus.in_pkt), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    run_group("t1", 8'h01, 8'h02, 8'h03, 8'h04, 4'b0000,
              1'b0, 1'b0);

    // back-to-back: second group held until accepted
    s2 = '{8'hFB, 8'h11, 8'h22, 8'h33,
           8'h44, 8'h55, 8'h66, 8'hFD};
    k2 = '{1'b1, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b1};
    drive(8'hFB, 8'h11, 8'h22, 8'h33, 4'b0001);
    tick();
    drive(8'h44, 8'h55, 8'h66, 8'hFD, 4'b1000);
    chk("t2_pkt1", 32'(bus.in_pkt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_vld", 32'(bus.out_valid), 32'd1);
      chk("t2_dat", 32'(bus.out_data), 32'(s2[i]));
      chk("t2_k", 32'(bus.out_k), 32'(k2[i]));
      chk("t2_err", 32'(bus.frame_err), 32'd0);
      if (i == 4) begin
        chk("t2_pkt2", 32'(bus.in_pkt), 32'd0);
      end
      tick();
      if (i == 3) bus.in_valid = 1'b0;
    end
    chk("t2_idle", 32'(bus.out_valid), 32'd0);

    run_group("t3", 8'h10, 8'hFB, 8'h20, 8'h30, 4'b0010,
              1'b1, 1'b0);

    // back-pressure while byte 02 is presented
    drive(8'h01, 8'h02, 8'h03, 8'h04, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_b0", 32'(bus.out_data), 32'h01);
    tick();
    chk("t4_b1", 32'(bus.out_data), 32'h02);
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      chk("t4_hold", 32'(bus.out_data), 32'h02);
      chk("t4_hvld", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_b2", 32'(bus.out_data), 32'h03);
    tick();
    chk("t4_b3", 32'(bus.out_data), 32'h04);
    chk("t4_rdy3", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t4_idle", 32'(bus.out_valid), 32'd0);

    // reset in the middle of a packet group
    drive(8'hFB, 8'h02, 8'h03, 8'h04, 4'b0001);
    tick();
    bus.in_valid = 1'b0;
    chk("t5_pkt", 32'(bus.in_pkt), 32'd1);
    tick();
    chk("t5_b1", 32'(bus.out_data), 32'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_vld", 32'(bus.out_valid), 32'd0);
    chk("t5_pkt0", 32'(bus.in_pkt), 32'd0);
    chk("t5_rdy", 32'(bus.in_ready), 32'd1);
    chk("t5_err", 32'(bus.frame_err), 32'd0);
    tick();
    chk("t5_gone", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t5_gone2", 32'(bus.out_valid), 32'd0);

    run_group("t6", 8'hFD, 8'hAA, 8'hBB, 8'hCC, 4'b0001,
              1'b1, 1'b0);
    run_group("t7", 8'h01, 8'h02, 8'h03, 8'hFE, 4'b1000,
              1'b1, 1'b0);
    run_group("t8", 8'h5C, 8'h02, 8'h03, 8'h04, 4'b0001,
              1'b0, 1'b1);
    run_group("t9", 8'hFB, 8'h02, 8'h03, 8'h04, 4'b0001,
              1'b1, 1'b1);
    run_group("t10", 8'h01, 8'h02, 8'h03, 8'hFE, 4'b1000,
              1'b0, 1'b0);
    run_group("t11", 8'hFB, 8'h01, 8'h02, 8'hFD, 4'b1001,
              1'b0, 1'b0);
    run_group("t12", 8'hFB, 8'h01, 8'h02, 8'hFD, 4'b0000,
              1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
